// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Derives a pixel-rate enable from the system clock and runs one horizontal and
// one vertical counter. DrawX/DrawY, syncs, blanking and the line/frame strobes
// all come from that single counter pair, so they are mutually aligned.
// Optional feature: define VGA_FRAME_CNT_EN to build the 16-bit completed-frame
// counter; otherwise frame_count is tied to zero.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        pixel_ce,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic [9:0]       hc;
  logic [9:0]       vc;
  logic [9:0]       hc_next;
  logic [9:0]       vc_next;
  logic             hc_last;
  logic             vc_last;
  logic             frame_wrap;
  logic             hs_reg;
  logic             vs_reg;
  logic             blank_n_reg;

  // True while pos lies in the half-open window [lo, hi).
  function automatic logic in_window(input logic [9:0] pos,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  // Active-low sync level for a counter position.
  function automatic logic sync_level(input logic [9:0] pos,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
    return ~in_window(pos, lo, hi);
  endfunction

  // Wrap-around increment of a raster counter.
  function automatic logic [9:0] wrap_inc(input logic [9:0] cnt,
                                          input logic       at_last);
    return at_last ? 10'd0 : cnt + 10'd1;
  endfunction

  assign div_last   = (div_cnt == DIV_LAST);
  // Gated by Reset so the enable drops the instant Reset rises, not at the next edge.
  assign pixel_ce   = div_last & ~Reset;

  assign hc_last    = (hc == H_LAST);
  assign vc_last    = (vc == V_LAST);
  assign frame_wrap = pixel_ce & hc_last & vc_last;

  // Next-counter values feed the sync/blank registers so they land on the same
  // edge as the coordinates they describe.
  always_comb begin
    hc_next = hc;
    vc_next = vc;
    if (pixel_ce) begin
      hc_next = wrap_inc(hc, hc_last);
      if (hc_last) begin
        vc_next = wrap_inc(vc, vc_last);
      end
    end
  end

  // Clock divider: counts 0..CLK_DIV-1 and wraps; pixel_ce marks the last phase.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
    end else if (div_last) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Horizontal and vertical position counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hc <= 10'd0;
      vc <= 10'd0;
    end else begin
      hc <= hc_next;
      vc <= vc_next;
    end
  end

  // Registered syncs and blanking, decoded from the next counter position.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hs_reg      <= 1'b1;
      vs_reg      <= 1'b1;
      blank_n_reg <= 1'b1;
    end else begin
      hs_reg      <= sync_level(hc_next, HS_START, HS_END);
      vs_reg      <= sync_level(vc_next, VS_START, VS_END);
      blank_n_reg <= (hc_next < H_VIS_END) && (vc_next < V_VIS_END);
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  // Completed-frame counter; rolls over from 0xFFFF to 0x0000.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt <= 16'd0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_count = frame_cnt;
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
  assign frame_count       = 16'd0;
`endif

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign VGA_HS      = hs_reg;
  assign VGA_VS      = vs_reg;
  assign VGA_BLANK_N = blank_n_reg;
  assign VGA_SYNC_N  = 1'b0;
  assign line_start  = pixel_ce & (hc == 10'd0);
  assign frame_start = line_start & (vc == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three instances of vga_timing_gen every cycle
// against a reference built from the number of clock edges since reset release:
// default timing, default timing with CLK_DIV=1, and a tiny raster so whole
// frames fit in a short run. Expected values go into a scoreboard queue before
// each edge and are popped after it.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        ce;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        sn;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic d_ce, d_hs, d_vs, d_bn, d_sn, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [15:0] d_fc;
  logic f_ce, f_hs, f_vs, f_bn, f_sn, f_ls, f_fs;
  logic [9:0] f_x, f_y;
  logic [15:0] f_fc;
  logic s_ce, s_hs, s_vs, s_bn, s_sn, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic [15:0] s_fc;

  vga_timing_gen dut_dflt (
    .Clk(Clk), .Reset(Reset), .pixel_ce(d_ce), .DrawX(d_x), .DrawY(d_y),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_bn), .VGA_SYNC_N(d_sn),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(.CLK_DIV(1)) dut_fast (
    .Clk(Clk), .Reset(Reset), .pixel_ce(f_ce), .DrawX(f_x), .DrawY(f_y),
    .VGA_HS(f_hs), .VGA_VS(f_vs), .VGA_BLANK_N(f_bn), .VGA_SYNC_N(f_sn),
    .line_start(f_ls), .frame_start(f_fs), .frame_count(f_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(2)
  ) dut_small (
    .Clk(Clk), .Reset(Reset), .pixel_ce(s_ce), .DrawX(s_x), .DrawY(s_y),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  obs_t obs_d, obs_f, obs_s;
  assign obs_d = {d_ce, d_x, d_y, d_hs, d_vs, d_bn, d_sn, d_ls, d_fs, d_fc};
  assign obs_f = {f_ce, f_x, f_y, f_hs, f_vs, f_bn, f_sn, f_ls, f_fs, f_fc};
  assign obs_s = {s_ce, s_x, s_y, s_hs, s_vs, s_bn, s_sn, s_ls, s_fs, s_fc};

  int   checks = 0;
  int   errors = 0;
  int   t = 0;
  bit   in_rst = 1'b1;
  obs_t sb[$];

  // Expected outputs tt edges after reset release (or held in reset).
  function automatic obs_t model(input int tt, input bit r,
                                 input int hv, input int hfp, input int hsw, input int hbp,
                                 input int vv, input int vfp, input int vsw, input int vbp,
                                 input int dv);
    obs_t e;
    int p, ht, vt, hc, vc;
    e = '0;
    if (r) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.bn = 1'b1;
      return e;
    end
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    p  = tt / dv;
    hc = p % ht;
    vc = (p / ht) % vt;
    e.ce = ((tt % dv) == dv - 1);
    e.x  = 10'(hc);
    e.y  = 10'(vc);
    e.hs = !((hc >= hv + hfp) && (hc < hv + hfp + hsw));
    e.vs = !((vc >= vv + vfp) && (vc < vv + vfp + vsw));
    e.bn = (hc < hv) && (vc < vv);
    e.sn = 1'b0;
    e.ls = e.ce && (hc == 0);
    e.fs = e.ls && (vc == 0);
`ifdef VGA_FRAME_CNT_EN
    e.fc = 16'((p / (ht * vt)) % 65536);
`else
    e.fc = 16'd0;
`endif
    return e;
  endfunction

  task automatic push_all();
    sb.push_back(model(t, in_rst, 640, 16, 96, 48, 480, 10, 2, 33, 2));
    sb.push_back(model(t, in_rst, 640, 16, 96, 48, 480, 10, 2, 33, 1));
    sb.push_back(model(t, in_rst, 8, 2, 3, 2, 6, 2, 2, 3, 2));
  endtask

  task automatic compare(input string tag, input obs_t o);
    obs_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s t=%0d scoreboard empty, observed=%h", tag, t, o);
      return;
    end
    e = sb.pop_front();
    assert (o === e) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, o, e);
    end
  endtask

  task automatic check_all();
    compare("dflt", obs_d);
    compare("fast", obs_f);
    compare("small", obs_s);
  endtask

  task automatic tick();
    t++;
    push_all();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int hs_low_d = 0;
  int ls_cnt_d = 0;
  int ls_cnt_f = 0;
  int fs_cnt_s = 0;
  int exp_fc;

  initial begin
    // Reset held across clock edges.
    Reset  = 1'b1;
    in_rst = 1'b1;
    t = 0;
    repeat (2) @(posedge Clk);
    push_all();
    #1;
    check_all();

    // Release between edges; cycle 0 starts now.
    #2;
    Reset  = 1'b0;
    in_rst = 1'b0;
    t = 0;
    push_all();
    #1;
    check_all();

    // First pass: one full default line plus part of the next, several small frames.
    while (t < 2201) begin
      tick();
      if (t <= 1601) begin
        if (!d_hs && t < 1600) hs_low_d++;
        if (d_ls) ls_cnt_d++;
        if (f_ls) ls_cnt_f++;
      end
      if (t < 1170 && s_fs) fs_cnt_s++;
    end
    check_val("hs_low_cycles_dflt", hs_low_d, 192);
    check_val("line_start_pulses_dflt", ls_cnt_d, 2);
    check_val("line_start_pulses_fast", ls_cnt_f, 2);
    check_val("frame_start_pulses_small", fs_cnt_s, 3);
    check_val("drawx_before_reset", int'(d_x), 300);
    check_val("drawy_before_reset", int'(d_y), 1);

    // Asynchronous reset mid-line: outputs must clear without a clock edge.
    #2;
    Reset  = 1'b1;
    in_rst = 1'b1;
    push_all();
    #1;
    check_all();
    push_all();
    @(posedge Clk);
    #1;
    check_all();

    // Release again; the sequence restarts exactly as after the first release.
    #2;
    Reset  = 1'b0;
    in_rst = 1'b0;
    t = 0;
    push_all();
    #1;
    check_all();
    repeat (1200) tick();

`ifdef VGA_FRAME_CNT_EN
    exp_fc = 3;
`else
    exp_fc = 0;
`endif
    check_val("frame_count_small_after_3_frames", int'(s_fc), exp_fc);
    check_val("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
